fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the RISC-V core: the only block that drives the PC register's select/new-value inputs. It chooses among hold (stall), trap vector, branch/jump redirect and sequential advance. It squashes wrong-path fetches after a redirect and flags misaligned targets. It sits between the PC register, the synchronous instruction memory (1-cycle read latency) and the decode stage.

## Interface
Parameters:
- AWIDTH, 32, address width
- RESET_PC_VAL, {AWIDTH{1'b0}}, must equal the PC register's reset value
- KILL_CYCLES, 2, bubbles inserted after a redirect or trap (1..7)

Ports:
- clk  in  1  core clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- stall_in  in  1  hazard unit freezes fetch
- redirect_valid_in  in  1  taken branch/jump resolved in execute
- redirect_target_in  in  AWIDTH  redirect address
- trap_valid_in  in  1  exception/ecall request
- trap_vector_in  in  AWIDTH  trap handler address
- pc_in  in  AWIDTH  current PC register value
- pc_sel_out  out  1  to PC register: 1 = load pc_new_out, 0 = PC+4
- pc_new_out  out  AWIDTH  value loaded when pc_sel_out=1
- fetch_valid_out  out  1  instruction word on imem output is live
- misalign_err_out  out  1  one-cycle pulse: redirect target bits[1:0] != 0
- redirect_count_out  out  32  saturating count of accepted redirects and traps

## Operation
- Combinational next-PC priority per cycle: rst > trap_valid_in > redirect_valid_in > stall_in > sequential.
  - Trap: pc_sel_out=1, pc_new_out=trap_vector_in with bits[1:0] forced to 0.
  - Redirect: pc_sel_out=1, pc_new_out={redirect_target_in[AWIDTH-1:2],2'b00}.
  - Stall: pc_sel_out=1, pc_new_out=pc_in, so the PC holds.
  - Sequential: pc_sel_out=0, pc_new_out=pc_in (don't-care, driven for determinism).
- FSM states: BOOT, RUN, KILL.
  - BOOT: entered on rst. fetch_valid_out=0. Leaves to RUN on the first non-reset cycle unless stall_in=1. A trap or redirect in BOOT goes to KILL.
  - RUN: fetch_valid_out=1. An accepted trap or redirect loads kill_cnt=KILL_CYCLES and goes to KILL.
  - KILL: fetch_valid_out=0. kill_cnt decrements each non-stalled cycle. At kill_cnt==1 with no stall, goes to RUN.
    - A new trap or redirect in KILL reloads kill_cnt=KILL_CYCLES and stays in KILL.
- stall_in freezes the FSM state, kill_cnt and fetch_valid_out in every state. A trap or redirect overrides a stall.
- misalign_err_out: registered. It is 1 in the cycle after an accepted redirect (trap not asserted) whose target bits[1:0] != 0. The target is still taken, aligned.
- redirect_count_out: +1 per accepted trap or redirect. Saturates at 32'hFFFF_FFFF.

## Timing
- Reset values: state=BOOT, kill_cnt=0, fetch_valid_out=0, misalign_err_out=0, redirect_count_out=0.
- During rst: pc_sel_out=1, pc_new_out=RESET_PC_VAL.
- Fetch at PC p in cycle t puts its instruction on imem in cycle t+1. fetch_valid_out in t+1 qualifies it.
- Redirect or trap accepted in cycle t:
  - PC = target in t+1.
  - fetch_valid_out=0 for cycles t+1 .. t+KILL_CYCLES (stall cycles extend this window).
  - fetch_valid_out=1 from t+KILL_CYCLES+1 onward.
- Trap and redirect in the same cycle: the trap wins, the counter counts once, and there is no misalign pulse.
- Redirect in the last KILL cycle: the kill window restarts and there is no RUN cycle in between.
- rst mid-KILL: the next cycle is BOOT and the counters clear.

## Structure
- Shared package riscv_fetch_pkg holds:
  - the FSM state encoding localparams (BOOT=2'd0, RUN=2'd1, KILL=2'd2)
  - the instruction alignment constant (2 low bits)
- No new sub-module. State, kill_cnt and redirect_count_out use the codebase's REGISTER_R reset-register primitive.
- The PC register stays outside. The top level wires pc_sel_out/pc_new_out to it and its output back to pc_in.

## Test plan
- Reset release with RESET_PC_VAL=32'h1000 → PC 0x1000, 0x1004, 0x1008. fetch_valid_out=0 in the first post-reset cycle, then 1.
- Redirect to 0x2000 at cycle t with KILL_CYCLES=2 → PC=0x2000 at t+1. fetch_valid_out=0 at t+1 and t+2, 1 at t+3. redirect_count_out=1.
- Trap (vector 0x100) and redirect (0x2000) in the same cycle → PC=0x100, count +1 only, misalign_err_out stays 0.
- stall_in=1 for 3 cycles in RUN at PC 0x1008 → pc_sel_out=1, pc_new_out=0x1008, and the PC holds. A stall inside KILL extends the bubble window by 3 cycles.
- Redirect to 0x2002 → PC=0x2000, misalign_err_out=1 for exactly one cycle. A second redirect during KILL restarts the 2-cycle window.
- rst asserted mid-KILL → next cycle is BOOT with pc_new_out=RESET_PC_VAL, count=0. A preloaded counter of 32'hFFFF_FFFF does not wrap on the next redirect.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-sequencer constants: FSM state encoding and instruction alignment.
package riscv_fetch_pkg;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] KILL = 2'd2;

  localparam int ALIGN_BITS = 2;
  localparam int KILL_W     = 3;

endpackage

// File: rtl/REGISTER_R.sv
// Reset-register primitive: D flip-flop bank with synchronous active-high reset to INIT.
module REGISTER_R #(
  parameter int           N    = 1,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= INIT;
    else     q <= d;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: selects the next PC (reset/trap/redirect/stall/sequential),
// squashes wrong-path fetches after a redirect and flags misaligned targets.
//
// state | meaning
// BOOT  | first cycle after reset, imem output not yet valid
// RUN   | sequential fetch, imem output valid
// KILL  | wrong-path bubbles after a redirect or trap, counted by kill_cnt
module fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int                AWIDTH       = 32,
  parameter logic [AWIDTH-1:0] RESET_PC_VAL = '0,
  parameter int                KILL_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect_valid_in,
  input  logic [AWIDTH-1:0] redirect_target_in,
  input  logic              trap_valid_in,
  input  logic [AWIDTH-1:0] trap_vector_in,
  input  logic [AWIDTH-1:0] pc_in,
  output logic              pc_sel_out,
  output logic [AWIDTH-1:0] pc_new_out,
  output logic              fetch_valid_out,
  output logic              misalign_err_out,
  output logic [31:0]       redirect_count_out
);

  localparam logic [AWIDTH-1:0] ALIGN_MASK = AWIDTH'((1 << ALIGN_BITS) - 1);
  localparam logic [KILL_W-1:0] KILL_LOAD  = KILL_W'(KILL_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [KILL_W-1:0] kill_q, kill_d;
  logic [31:0]       count_d;
  logic              misalign_d;
  logic              accept;

  assign accept = !rst && (trap_valid_in || redirect_valid_in);

  always_comb begin
    pc_sel_out = 1'b1;
    pc_new_out = pc_in;
    if (rst)                    pc_new_out = RESET_PC_VAL;
    else if (trap_valid_in)     pc_new_out = trap_vector_in & ~ALIGN_MASK;
    else if (redirect_valid_in) pc_new_out = redirect_target_in & ~ALIGN_MASK;
    else if (!stall_in)         pc_sel_out = 1'b0;
  end

  // A redirect/trap overrides stall; otherwise stall freezes state and kill_cnt.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    if (accept) begin
      state_d = KILL;
      kill_d  = KILL_LOAD;
    end else if (!stall_in) begin
      case (state_q)
        BOOT: state_d = RUN;
        KILL: begin
          if (kill_q == KILL_W'(1)) begin
            state_d = RUN;
            kill_d  = '0;
          end else begin
            kill_d  = kill_q - KILL_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign misalign_d = !rst && !trap_valid_in && redirect_valid_in &&
                      ((redirect_target_in & ALIGN_MASK) != '0);

  always_comb begin
    count_d = redirect_count_out;
    if (accept && (redirect_count_out != 32'hFFFF_FFFF))
      count_d = redirect_count_out + 32'd1;
  end

  REGISTER_R #(.N(2), .INIT(BOOT)) u_state_reg (
    .clk (clk), .rst (rst), .d (state_d), .q (state_q)
  );

  REGISTER_R #(.N(KILL_W), .INIT('0)) u_kill_reg (
    .clk (clk), .rst (rst), .d (kill_d), .q (kill_q)
  );

  REGISTER_R #(.N(32), .INIT('0)) u_count_reg (
    .clk (clk), .rst (rst), .d (count_d), .q (redirect_count_out)
  );

  REGISTER_R #(.N(1), .INIT(1'b0)) u_misalign_reg (
    .clk (clk), .rst (rst), .d (misalign_d), .q (misalign_err_out)
  );

  assign fetch_valid_out = (state_q == RUN);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a behavioural PC register in the loop.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_target_in;
  logic        trap_valid_in;
  logic [31:0] trap_vector_in;
  logic [31:0] pc;
  logic        pc_sel_out;
  logic [31:0] pc_new_out;
  logic        fetch_valid_out;
  logic        misalign_err_out;
  logic [31:0] redirect_count_out;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .AWIDTH       (32),
    .RESET_PC_VAL (32'h1000),
    .KILL_CYCLES  (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_target_in (redirect_target_in),
    .trap_valid_in      (trap_valid_in),
    .trap_vector_in     (trap_vector_in),
    .pc_in              (pc),
    .pc_sel_out         (pc_sel_out),
    .pc_new_out         (pc_new_out),
    .fetch_valid_out    (fetch_valid_out),
    .misalign_err_out   (misalign_err_out),
    .redirect_count_out (redirect_count_out)
  );

  // External PC register.
  always @(posedge clk) pc <= pc_sel_out ? pc_new_out : pc + 32'd4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [31:0] exp_pc,
                             input logic exp_valid);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_valid"}, 32'(fetch_valid_out), 32'(exp_valid));
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0;
    redirect_valid_in = 1'b0; redirect_target_in = '0;
    trap_valid_in = 1'b0; trap_vector_in = '0;
    tick(); tick();
    chk("rst_sel", 32'(pc_sel_out), 32'd1);
    chk("rst_new", pc_new_out, 32'h1000);
    chk("rst_valid", 32'(fetch_valid_out), 32'd0);
    chk("rst_misalign", 32'(misalign_err_out), 32'd0);
    chk("rst_count", redirect_count_out, 32'd0);

    // Reset release: BOOT bubble then sequential fetch.
    tick(); rst = 1'b0; #1;
    check_cycle("boot", 32'h1000, 1'b0);
    chk("boot_sel", 32'(pc_sel_out), 32'd0);
    tick(); check_cycle("run1", 32'h1004, 1'b1);
    tick(); check_cycle("run2", 32'h1008, 1'b1);

    // Stall 3 cycles in RUN at 0x1008.
    stall_in = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_sel", 32'(pc_sel_out), 32'd1);
      chk("stall_new", pc_new_out, 32'h1008);
      check_cycle("stall_hold", 32'h1008, 1'b1);
      tick();
    end
    stall_in = 1'b0; #1;
    check_cycle("stall_end", 32'h1008, 1'b1);
    tick(); check_cycle("post_stall", 32'h100c, 1'b1);

    // Redirect to 0x2000.
    redirect_valid_in = 1'b1; redirect_target_in = 32'h2000; #1;
    chk("redir_sel", 32'(pc_sel_out), 32'd1);
    chk("redir_new", pc_new_out, 32'h2000);
    tick(); redirect_valid_in = 1'b0;
    check_cycle("redir_t1", 32'h2000, 1'b0);
    chk("redir_count", redirect_count_out, 32'd1);
    chk("redir_misalign", 32'(misalign_err_out), 32'd0);
    tick(); check_cycle("redir_t2", 32'h2004, 1'b0);
    tick(); check_cycle("redir_t3", 32'h2008, 1'b1);

    // Trap and misaligned redirect together: trap wins, no misalign pulse.
    trap_valid_in = 1'b1; trap_vector_in = 32'h103;
    redirect_valid_in = 1'b1; redirect_target_in = 32'h2002; #1;
    chk("trap_new", pc_new_out, 32'h100);
    tick(); trap_valid_in = 1'b0; redirect_valid_in = 1'b0;
    check_cycle("trap_t1", 32'h100, 1'b0);
    chk("trap_count", redirect_count_out, 32'd2);
    chk("trap_misalign", 32'(misalign_err_out), 32'd0);
    tick(); check_cycle("trap_t2", 32'h104, 1'b0);
    tick(); check_cycle("trap_t3", 32'h108, 1'b1);

    // Stall inside KILL extends the bubble window.
    redirect_valid_in = 1'b1; redirect_target_in = 32'h3000;
    tick(); redirect_valid_in = 1'b0;
    check_cycle("kstall_t1", 32'h3000, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_cycle("kstall_hold", 32'h3000, 1'b0);
    end
    stall_in = 1'b0;
    tick(); check_cycle("kstall_a", 32'h3004, 1'b0);
    tick(); check_cycle("kstall_b", 32'h3008, 1'b1);
    chk("kstall_count", redirect_count_out, 32'd3);

    // Misaligned redirect, then a redirect in the last KILL cycle.
    redirect_valid_in = 1'b1; redirect_target_in = 32'h2002; #1;
    chk("mis_new", pc_new_out, 32'h2000);
    tick(); redirect_valid_in = 1'b0;
    check_cycle("mis_t1", 32'h2000, 1'b0);
    chk("mis_pulse", 32'(misalign_err_out), 32'd1);
    chk("mis_count", redirect_count_out, 32'd4);
    tick(); check_cycle("mis_t2", 32'h2004, 1'b0);
    chk("mis_pulse_end", 32'(misalign_err_out), 32'd0);
    redirect_valid_in = 1'b1; redirect_target_in = 32'h4000;
    tick(); redirect_valid_in = 1'b0;
    check_cycle("rekill_t1", 32'h4000, 1'b0);
    chk("rekill_count", redirect_count_out, 32'd5);
    chk("rekill_misalign", 32'(misalign_err_out), 32'd0);
    tick(); check_cycle("rekill_t2", 32'h4004, 1'b0);
    tick(); check_cycle("rekill_t3", 32'h4008, 1'b1);

    // Reset asserted mid-KILL.
    redirect_valid_in = 1'b1; redirect_target_in = 32'h5000;
    tick(); redirect_valid_in = 1'b0;
    check_cycle("rk_kill", 32'h5000, 1'b0);
    rst = 1'b1; #1;
    chk("rk_sel", 32'(pc_sel_out), 32'd1);
    chk("rk_new", pc_new_out, 32'h1000);
    tick(); rst = 1'b0; #1;
    check_cycle("rk_boot", 32'h1000, 1'b0);
    chk("rk_count", redirect_count_out, 32'd0);
    tick(); check_cycle("rk_run", 32'h1004, 1'b1);

    // Saturation: preload the counter to all-ones, then redirect.
    force dut.u_count_reg.q = 32'hFFFF_FFFF;
    tick();
    release dut.u_count_reg.q;
    #1;
    chk("sat_preload", redirect_count_out, 32'hFFFF_FFFF);
    redirect_valid_in = 1'b1; redirect_target_in = 32'h6000;
    tick(); redirect_valid_in = 1'b0;
    check_cycle("sat_t1", 32'h6000, 1'b0);
    chk("sat_count", redirect_count_out, 32'hFFFF_FFFF);
    tick(); tick();
    check_cycle("sat_t3", 32'h6008, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
